// File: rtl/prf_pkg.sv
// prf_pkg: shared types and default constants for the physical register file
package prf_pkg;
  localparam int PRF_ADDR_WIDTH = 6;
  localparam int SP_REG_DEFAULT = 2;
  localparam logic [31:0] SP_RESET_VALUE_DEFAULT = 32'h7FFF_FFF0;
  typedef enum logic {PRF_INIT, PRF_RUN} prf_state_t;
  typedef logic [PRF_ADDR_WIDTH-1:0] phys_reg_t;
endpackage

// File: rtl/prf_multi_port_ready_if.sv
// prf_multi_port_ready_if: read, commit and alloc bundle; PRF_BYPASS_STATS_EN adds stat counters
interface prf_multi_port_ready_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_READ_PORTS = 6,
  parameter int NUM_COMMIT_PORTS = 3,
  parameter int NUM_ALLOC_PORTS = 3
);
  logic init_done;
  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0] read_addr;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] read_data;
  logic [NUM_READ_PORTS-1:0] read_ready;
  logic [NUM_COMMIT_PORTS-1:0] commit_enable;
  logic [NUM_COMMIT_PORTS-1:0][ADDR_WIDTH-1:0] commit_addr;
  logic [NUM_COMMIT_PORTS-1:0][DATA_WIDTH-1:0] commit_data;
  logic [NUM_ALLOC_PORTS-1:0] alloc_enable;
  logic [NUM_ALLOC_PORTS-1:0][ADDR_WIDTH-1:0] alloc_addr;
  logic flush;
`ifdef PRF_BYPASS_STATS_EN
  logic [31:0] bypass_hits;
  logic [15:0] commit_collisions;
  modport master (input init_done, read_data, read_ready, bypass_hits, commit_collisions,
                  output read_addr, commit_enable, commit_addr, commit_data, alloc_enable, alloc_addr, flush);
  modport slave (output init_done, read_data, read_ready, bypass_hits, commit_collisions,
                 input read_addr, commit_enable, commit_addr, commit_data, alloc_enable, alloc_addr, flush);
`else
  modport master (input init_done, read_data, read_ready,
                  output read_addr, commit_enable, commit_addr, commit_data, alloc_enable, alloc_addr, flush);
  modport slave (output init_done, read_data, read_ready,
                 input read_addr, commit_enable, commit_addr, commit_data, alloc_enable, alloc_addr, flush);
`endif
endinterface

// File: rtl/prf_read_bypass.sv
// prf_read_bypass: one read port's commit-forwarding match; highest commit port index wins
module prf_read_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_COMMIT_PORTS = 3
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [NUM_COMMIT_PORTS-1:0] commit_enable,
  input  logic [NUM_COMMIT_PORTS-1:0][ADDR_WIDTH-1:0] commit_addr,
  input  logic [NUM_COMMIT_PORTS-1:0][DATA_WIDTH-1:0] commit_data,
  input  logic [DATA_WIDTH-1:0] arr_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic hit
);
  always_comb begin
    data = arr_data;
    hit = 1'b0;
    for (int i = 0; i < NUM_COMMIT_PORTS; i++)
      if (commit_enable[i] && commit_addr[i] == addr && addr != '0) begin
        data = commit_data[i];
        hit = 1'b1;
      end
  end
endmodule

// File: rtl/prf_multi_port_ready.sv
// prf_multi_port_ready: multi-port PRF with ready bits, commit bypass and init sweep
// Optional PRF_BYPASS_STATS_EN adds saturating bypass_hits and commit_collisions counters.
module prf_multi_port_ready import prf_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGISTERS = 64,
  parameter int ADDR_WIDTH = $clog2(NUM_REGISTERS),
  parameter int NUM_READ_PORTS = 6,
  parameter int NUM_COMMIT_PORTS = 3,
  parameter int NUM_ALLOC_PORTS = 3,
  parameter int INIT_PER_CYCLE = 8,
  parameter int SP_REG = SP_REG_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] SP_RESET_VALUE = DATA_WIDTH'(SP_RESET_VALUE_DEFAULT)
) (
  input logic clk,
  input logic reset,
  prf_multi_port_ready_if.slave bus
);
  logic [DATA_WIDTH-1:0] mem [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] rdy;
  prf_state_t state, state_next;
  logic [ADDR_WIDTH-1:0] init_ptr;
  logic run, last_group;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] byp_data;
  logic [NUM_READ_PORTS-1:0] hit;
  assign run = state == PRF_RUN;
  assign last_group = init_ptr == ADDR_WIDTH'(NUM_REGISTERS - INIT_PER_CYCLE);
  always_ff @(posedge clk)
    if (reset) state <= PRF_INIT;
    else state <= state_next;
  always_comb state_next = (state == PRF_INIT && last_group) ? PRF_RUN : state;
  always_ff @(posedge clk)
    if (reset) init_ptr <= '0;
    else if (!run) init_ptr <= init_ptr + ADDR_WIDTH'(INIT_PER_CYCLE);
  // Array has no reset: the sweep rewrites every entry before RUN, register 0 included.
  always_ff @(posedge clk)
    if (!reset && !run)
      for (int k = 0; k < INIT_PER_CYCLE; k++) begin
        mem[init_ptr + ADDR_WIDTH'(k)] <= (init_ptr + ADDR_WIDTH'(k) == ADDR_WIDTH'(SP_REG)) ? SP_RESET_VALUE : '0;
        rdy[init_ptr + ADDR_WIDTH'(k)] <= 1'b1;
      end
    else if (!reset) begin
      if (bus.flush) rdy <= '1;
      for (int i = 0; i < NUM_COMMIT_PORTS; i++)
        if (bus.commit_enable[i] && bus.commit_addr[i] != '0) begin
          mem[bus.commit_addr[i]] <= bus.commit_data[i];
          rdy[bus.commit_addr[i]] <= 1'b1;
        end
      for (int j = 0; j < NUM_ALLOC_PORTS; j++)
        if (bus.alloc_enable[j] && bus.alloc_addr[j] != '0) rdy[bus.alloc_addr[j]] <= 1'b0;
    end
  for (genvar r = 0; r < NUM_READ_PORTS; r++) begin : g_read
    prf_read_bypass #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_COMMIT_PORTS(NUM_COMMIT_PORTS)
    ) u_byp (
      .addr(bus.read_addr[r]), .commit_enable(bus.commit_enable), .commit_addr(bus.commit_addr),
      .commit_data(bus.commit_data), .arr_data(mem[bus.read_addr[r]]), .data(byp_data[r]), .hit(hit[r])
    );
  end
  always_comb begin
    bus.init_done = run;
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      bus.read_data[r] = run ? byp_data[r] : '0;
      bus.read_ready[r] = run & (hit[r] | rdy[bus.read_addr[r]]);
    end
  end
`ifdef PRF_BYPASS_STATS_EN
  localparam int HW = $clog2(NUM_READ_PORTS + 1);
  logic [HW-1:0] hits_n;
  logic dup;
  logic [32:0] hits_sum;
  always_comb begin
    hits_n = '0;
    dup = 1'b0;
    for (int r = 0; r < NUM_READ_PORTS; r++) hits_n += HW'(hit[r]);
    for (int i = 0; i < NUM_COMMIT_PORTS; i++)
      for (int j = i + 1; j < NUM_COMMIT_PORTS; j++)
        if (bus.commit_enable[i] && bus.commit_enable[j] && bus.commit_addr[i] == bus.commit_addr[j] && bus.commit_addr[i] != '0)
          dup = 1'b1;
    hits_sum = {1'b0, bus.bypass_hits} + 33'(hits_n);
  end
  always_ff @(posedge clk)
    if (reset) begin
      bus.bypass_hits <= '0;
      bus.commit_collisions <= '0;
    end else if (run) begin
      bus.bypass_hits <= hits_sum[32] ? '1 : hits_sum[31:0];
      if (dup && bus.commit_collisions != '1) bus.commit_collisions <= bus.commit_collisions + 16'd1;
    end
`endif
endmodule

// File: tb/tb_prf_multi_port_ready.sv
// tb_prf_multi_port_ready: scoreboard bench with a spec-level register file model
module tb_prf_multi_port_ready;
  import prf_pkg::*;
  localparam int DW = 32, NR = 64, AW = 6, NRP = 6, NCP = 3, NAP = 3, GROUPS = 8;
  localparam logic [31:0] SP_VAL = 32'h7FFF_FFF0;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  prf_multi_port_ready_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ_PORTS(NRP),
    .NUM_COMMIT_PORTS(NCP), .NUM_ALLOC_PORTS(NAP)) bus ();
  prf_multi_port_ready dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic done;
    logic [NRP-1:0][DW-1:0] data;
    logic [NRP-1:0] ready;
    logic [31:0] hits;
    logic [15:0] coll;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [DW-1:0] m_data [NR];
  bit m_ready [NR];
  int init_left = 0;
  bit armed = 0;
  longint m_hits = 0;
  int m_coll = 0;
  task automatic chk(input string name, input int port, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s port %0d got %h expected %h at %0t", name, port, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("init_done", 0, 32'(bus.init_done), 32'(e.done));
      for (int p = 0; p < NRP; p++) begin
        chk("read_data", p, bus.read_data[p], e.data[p]);
        chk("read_ready", p, 32'(bus.read_ready[p]), 32'(e.ready[p]));
      end
`ifdef PRF_BYPASS_STATS_EN
      chk("bypass_hits", 0, bus.bypass_hits, e.hits);
      chk("commit_collisions", 0, 32'(bus.commit_collisions), 32'(e.coll));
`endif
    end
  task automatic idle();
    bus.read_addr = '0;
    bus.commit_enable = '0;
    bus.commit_addr = '0;
    bus.commit_data = '0;
    bus.alloc_enable = '0;
    bus.alloc_addr = '0;
    bus.flush = 1'b0;
  endtask
  // Predict this cycle's outputs from the current inputs, then advance the model over the edge.
  task automatic step();
    exp_t e;
    int nh = 0;
    bit dup = 0;
    phys_reg_t a;
    if (armed) begin
      e.done = init_left == 0;
      e.hits = m_hits[31:0];
      e.coll = m_coll[15:0];
      for (int p = 0; p < NRP; p++) begin
        e.data[p] = '0;
        e.ready[p] = 1'b0;
        if (e.done) begin
          a = bus.read_addr[p];
          e.data[p] = m_data[a];
          e.ready[p] = m_ready[a];
          if (a != 0) begin
            bit h = 0;
            for (int c = 0; c < NCP; c++)
              if (bus.commit_enable[c] && bus.commit_addr[c] == a) begin
                e.data[p] = bus.commit_data[c];
                e.ready[p] = 1'b1;
                h = 1;
              end
            nh += int'(h);
          end
        end
      end
      q.push_back(e);
    end
    if (reset) begin
      armed = 1;
      init_left = GROUPS;
      m_hits = 0;
      m_coll = 0;
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0) begin
        for (int i = 0; i < NR; i++) begin
          m_data[i] = '0;
          m_ready[i] = 1;
        end
        m_data[2] = SP_VAL;
      end
    end else if (armed) begin
      m_hits = (m_hits + nh > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_hits + nh;
      for (int c = 0; c < NCP; c++)
        for (int d = c + 1; d < NCP; d++)
          if (bus.commit_enable[c] && bus.commit_enable[d] && bus.commit_addr[c] == bus.commit_addr[d] && bus.commit_addr[c] != 0)
            dup = 1;
      if (dup && m_coll < 65535) m_coll++;
      if (bus.flush) for (int i = 0; i < NR; i++) m_ready[i] = 1;
      for (int c = 0; c < NCP; c++)
        if (bus.commit_enable[c] && bus.commit_addr[c] != 0) begin
          m_data[bus.commit_addr[c]] = bus.commit_data[c];
          m_ready[bus.commit_addr[c]] = 1;
        end
      for (int j = 0; j < NAP; j++)
        if (bus.alloc_enable[j] && bus.alloc_addr[j] != 0) m_ready[bus.alloc_addr[j]] = 0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    bus.read_addr[0] = 6'd2;
    bus.read_addr[1] = 6'd5;
    repeat (10) step();
    idle(); bus.alloc_enable[0] = 1'b1; bus.alloc_addr[0] = 6'd10; bus.read_addr[0] = 6'd10; step();
    idle(); bus.read_addr[0] = 6'd10; step();
    bus.commit_enable[0] = 1'b1; bus.commit_addr[0] = 6'd10; bus.commit_data[0] = 32'hDEADBEEF; step();
    idle(); bus.read_addr[0] = 6'd10; step();
    bus.commit_enable = 3'b101; bus.commit_addr[0] = 6'd7; bus.commit_addr[2] = 6'd7;
    bus.commit_data[0] = 32'h11; bus.commit_data[2] = 32'h33; bus.read_addr[1] = 6'd7; step();
    idle(); bus.read_addr[1] = 6'd7; step();
    bus.commit_enable[1] = 1'b1; bus.commit_addr[1] = 6'd12; bus.commit_data[1] = 32'hCAFE_0012;
    bus.alloc_enable[2] = 1'b1; bus.alloc_addr[2] = 6'd12; bus.read_addr[2] = 6'd12; step();
    idle(); bus.read_addr[2] = 6'd12; step();
    bus.commit_enable[0] = 1'b1; bus.commit_addr[0] = 6'd0; bus.commit_data[0] = 32'hFFFF;
    bus.alloc_enable[0] = 1'b1; bus.alloc_addr[0] = 6'd0; bus.read_addr = '0; step();
    idle(); step();
    bus.alloc_enable = 3'b011; bus.alloc_addr[0] = 6'd20; bus.alloc_addr[1] = 6'd21; step();
    idle(); bus.flush = 1'b1; bus.alloc_enable[0] = 1'b1; bus.alloc_addr[0] = 6'd21; step();
    idle(); bus.read_addr[0] = 6'd20; bus.read_addr[1] = 6'd21; step();
    reset = 1'b1; step();
    reset = 1'b0;
    repeat (3) begin
      bus.commit_enable[0] = 1'b1; bus.commit_addr[0] = 6'd30; bus.commit_data[0] = $urandom;
      bus.read_addr[0] = 6'd30; step();
    end
    reset = 1'b1; step();
    reset = 1'b0;
    repeat (10) begin
      bus.commit_enable[0] = !bus.init_done; bus.read_addr[0] = 6'd30; step();
    end
    idle();
    repeat (400) begin
      for (int p = 0; p < NRP; p++) bus.read_addr[p] = AW'($urandom_range(0, 15));
      for (int c = 0; c < NCP; c++) begin
        bus.commit_enable[c] = $urandom_range(0, 1) == 1;
        bus.commit_addr[c] = AW'($urandom_range(0, 15));
        bus.commit_data[c] = $urandom;
      end
      for (int j = 0; j < NAP; j++) begin
        bus.alloc_enable[j] = $urandom_range(0, 2) == 0;
        bus.alloc_addr[j] = AW'($urandom_range(0, 15));
      end
      bus.flush = $urandom_range(0, 15) == 0;
      reset = $urandom_range(0, 199) == 0;
      step();
    end
    reset = 1'b0;
    idle();
    step();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prf_multi_port_ready.md
Name: prf_multi_port_ready

Overview:
Parametrised successor of the dispatch-stage physical register file.
- Generalises read, commit and allocate port counts.
- Adds a per-register ready bit: cleared on rename allocation, set on commit. Read ports return data plus ready, with same-cycle commit bypass.
- After reset, a multi-cycle init sweep clears the array, so the large array needs no single-cycle reset fan-out.

Parameters:
DATA_WIDTH, 32, register data width
NUM_REGISTERS, 64, physical register count (power of 2)
ADDR_WIDTH, $clog2(NUM_REGISTERS), physical register index width
NUM_READ_PORTS, 6, combinational read ports (2 per dispatched instruction)
NUM_COMMIT_PORTS, 3, write/commit ports
NUM_ALLOC_PORTS, 3, rename allocation ports (clear ready)
INIT_PER_CYCLE, 8, registers cleared per init cycle (divides NUM_REGISTERS)
SP_REG, 2, index preset to SP_RESET_VALUE during init
SP_RESET_VALUE, 32'h7FFFFFF0, stack pointer initial value

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
init_done  out  1  high once the init sweep completes
read_addr  in  [NUM_READ_PORTS-1:0][ADDR_WIDTH]  read indices
read_data  out  [NUM_READ_PORTS-1:0][DATA_WIDTH]  read data
read_ready  out  [NUM_READ_PORTS-1:0]  operand-ready flags
commit_enable  in  [NUM_COMMIT_PORTS-1:0]  commit strobes
commit_addr  in  [NUM_COMMIT_PORTS-1:0][ADDR_WIDTH]  commit indices
commit_data  in  [NUM_COMMIT_PORTS-1:0][DATA_WIDTH]  commit data
alloc_enable  in  [NUM_ALLOC_PORTS-1:0]  allocation strobes
alloc_addr  in  [NUM_ALLOC_PORTS-1:0][ADDR_WIDTH]  newly allocated destinations
flush  in  1  set all ready bits (pipeline drained)

Behaviour:
- Single clock domain. Reset is synchronous and active-high; the port names clk and reset are fixed.
- FSM states:
  - INIT: entered on reset. init_ptr=0, init_done=0. Each cycle clears INIT_PER_CYCLE registers (data=0, ready=1) and init_ptr advances.
  - SP_REG is written with SP_RESET_VALUE in the same cycle it is swept.
  - INIT -> RUN after the last group, i.e. NUM_REGISTERS/INIT_PER_CYCLE cycles after reset deasserts. init_done=1 in RUN.
  - reset asserted in any state, including mid-INIT, returns to INIT with init_ptr=0. RUN has no other exit.
- Reset values: init_done=0. During INIT, read_data=0 and read_ready=0 on all ports. Commit, alloc and flush are ignored.
- RUN, writes (next edge):
  - commit_enable[i] with addr!=0: data[addr]<=commit_data[i], ready[addr]<=1.
  - Duplicate commit addresses in one cycle: highest port index wins.
- RUN, alloc: alloc_enable[j] with addr!=0 sets ready[addr]<=0.
  - Commit and alloc to the same index in one cycle: data takes the commit, ready=0 (alloc wins).
- RUN, flush: all ready bits set to 1. Same-cycle alloc still clears its bit. Data is unaffected.
- Register 0: data always 0, ready always 1. Writes and allocs to it are ignored.
- Reads (combinational, zero latency):
  - If any enabled commit matches a nonzero read_addr, return the highest-index matching commit_data with ready=1.
  - Otherwise return the array value and ready bit.
  - Same-cycle alloc does not affect the read (the ready bit updates at the next edge).

Optional Feature:
PRF_BYPASS_STATS_EN
- Defined:
  - Adds outputs bypass_hits [31:0] and commit_collisions [15:0].
  - bypass_hits increments by the number of read ports served by bypass each RUN cycle.
  - commit_collisions increments once per cycle with duplicate enabled nonzero commit addresses.
  - Both saturate, and are cleared by reset.
- Undefined: neither the ports nor the logic exist.

Decomposition:
- Package prf_pkg:
  - prf_state_t enum {PRF_INIT, PRF_RUN}.
  - phys_reg_t typedef of logic [ADDR_WIDTH-1:0].
  - Default SP constants.
- One sub-module, prf_read_bypass: a single read port's priority match across commit ports, instantiated NUM_READ_PORTS times via generate.

Test Plan:
- Init sweep: pulse reset one cycle, read addr 2 and 5 each cycle. Expect:
  - read_ready=0, data=0 for 8 cycles.
  - init_done=1 at cycle 8.
  - Then addr2 reads 7FFFFFF0, addr5 reads 0, both ready=1.
- Alloc/commit:
  - alloc addr 10. Next cycle read 10 gives ready=0.
  - commit 10=0xDEADBEEF. Same cycle the read gives 0xDEADBEEF with ready=1 via bypass. Next cycle the array read is also ready=1.
- Collision: commit ports 0 and 2 both write addr 7 (0x11, 0x33) in one cycle. Expect:
  - Bypass and array both hold 0x33.
  - commit_collisions=1 with PRF_BYPASS_STATS_EN.
- Commit+alloc same index 12 in one cycle: next cycle data=commit value, ready=0.
- Register 0: commit 0 with 0xFFFF and alloc 0. Reads stay 0 with ready=1.
- Reset mid-INIT at cycle 3: the sweep restarts, and init_done rises 8 cycles after reset deasserts. Commits issued during INIT are ignored.
